// File: rtl/program_loader.sv
// Framed byte-stream loader for the 64x16 instruction memory: header N, 2N data bytes
// (high byte first), XOR checksum; releases the CPU once the checksum matches.
module program_loader #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              done,
   output logic              error,
   output logic              cpu_run
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_HI   = 3'd2,
      S_LO   = 3'd3,
      S_CHK  = 3'd4,
      S_DONE = 3'd5,
      S_ERR  = 3'd6
   } state_t;

   localparam logic [7:0] L_DEPTH = 8'(DEPTH);

   state_t              r_state;
   logic [7:0]          r_n;
   logic [ADDR_W:0]     r_cnt;
   logic [7:0]          r_acc;
   logic [7:0]          r_hi;
   logic                r_wr_en;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [15:0]         r_wr_data;
   logic                r_done;
   logic                r_error;
   logic                r_cpu_run;

   logic                w_ready;
   logic                w_xfer;
   logic [ADDR_W:0]     w_cnt_next;
   logic                w_last;

   // Ready depends only on the current state, never on byte_valid.
   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         S_HDR, S_HI, S_LO, S_CHK: w_ready = 1'b1;
         default:                  w_ready = 1'b0;
      endcase
   end

   assign w_xfer     = byte_valid && w_ready;
   assign w_cnt_next = r_cnt + {{ADDR_W{1'b0}}, 1'b1};
   // Counter is one bit wider than the address so N == DEPTH terminates cleanly.
   assign w_last     = (8'(w_cnt_next) == r_n);

   // Frame sequencing, memory write strobe and sticky status flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_n       <= 8'd0;
         r_cnt     <= '0;
         r_acc     <= 8'd0;
         r_hi      <= 8'd0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= 16'd0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_cpu_run <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         if (start) begin
            r_state   <= S_HDR;
            r_cnt     <= '0;
            r_acc     <= 8'd0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_cpu_run <= 1'b0;
         end else begin
            case (r_state)
               S_HDR: begin
                  if (w_xfer) begin
                     r_n <= byte_in;
                     if ((byte_in == 8'd0) || (byte_in > L_DEPTH)) begin
                        r_state <= S_ERR;
                        r_error <= 1'b1;
                     end else begin
                        r_cnt   <= '0;
                        r_acc   <= 8'd0;
                        r_state <= S_HI;
                     end
                  end else begin
                     r_state <= S_HDR;
                  end
               end
               S_HI: begin
                  if (w_xfer) begin
                     r_hi    <= byte_in;
                     r_acc   <= r_acc ^ byte_in;
                     r_state <= S_LO;
                  end else begin
                     r_state <= S_HI;
                  end
               end
               S_LO: begin
                  if (w_xfer) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_cnt[ADDR_W-1:0];
                     r_wr_data <= {r_hi, byte_in};
                     r_acc     <= r_acc ^ byte_in;
                     r_cnt     <= w_cnt_next;
                     r_state   <= w_last ? S_CHK : S_HI;
                  end else begin
                     r_state <= S_LO;
                  end
               end
               S_CHK: begin
                  if (w_xfer) begin
                     if (byte_in == r_acc) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_cpu_run <= 1'b1;
                     end else begin
                        r_state <= S_ERR;
                        r_error <= 1'b1;
                     end
                  end else begin
                     r_state <= S_CHK;
                  end
               end
               S_IDLE:  r_state <= S_IDLE;
               S_DONE:  r_state <= S_DONE;
               S_ERR:   r_state <= S_ERR;
               default: begin
                  r_state   <= S_ERR;
                  r_error   <= 1'b1;
                  r_done    <= 1'b0;
                  r_cpu_run <= 1'b0;
               end
            endcase
         end
      end
   end

   assign byte_ready = w_ready;
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign done       = r_done;
   assign error      = r_error;
   assign cpu_run    = r_cpu_run;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as frames are sent,
// a negedge monitor pops and compares every wr_en, and flags are checked after each frame.
module tb_program_loader;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [15:0] wr_data;
   logic        done;
   logic        error;
   logic        cpu_run;

   int total = 0;
   int bad   = 0;
   logic [21:0] exp_q[$];

   program_loader #(.ADDR_W(6), .DEPTH(64)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .error(error),
      .cpu_run(cpu_run)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the expected queue.
   always @(negedge clock) begin
      if (reset_n && wr_en) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", wr_addr, wr_data);
         end else begin
            logic [21:0] e;
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               bad++;
               $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                        wr_addr, wr_data, e[21:16], e[15:0]);
            end
         end
         total++;
         if (done !== 1'b0) begin
            bad++;
            $display("FAIL write_before_done: got done=%b expected 0", done);
         end
      end
   end

   task automatic push_wr(input logic [5:0] a, input logic [15:0] d);
      exp_q.push_back({a, d});
   endtask

   // Caller sits at a negedge; start is offered together with a junk byte that must be dropped.
   task automatic do_start();
      start      = 1'b1;
      byte_valid = 1'b1;
      byte_in    = 8'h99;
      @(negedge clock);
      start      = 1'b0;
      byte_valid = 1'b0;
      check("ready_after_start", {31'd0, byte_ready}, 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_valid = 1'b1;
      byte_in    = b;
      while (!byte_ready && n < 8) begin
         @(negedge clock);
         n++;
      end
      check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
      @(negedge clock);
      byte_valid = 1'b0;
      byte_in    = 8'h5A;
   endtask

   task automatic check_flags(input string name, input logic d, input logic e, input logic r);
      check({name, "_done"},    {31'd0, done},    {31'd0, d});
      check({name, "_error"},   {31'd0, error},   {31'd0, e});
      check({name, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, r});
   endtask

   task automatic check_drained(input string name);
      #2;
      check({name, "_queue_empty"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      repeat (3) @(negedge clock);
      check("rst_ready",   {31'd0, byte_ready}, 32'd0);
      check("rst_wr_en",   {31'd0, wr_en},      32'd0);
      check("rst_wr_addr", {26'd0, wr_addr},    32'd0);
      check("rst_wr_data", {16'd0, wr_data},    32'd0);
      check_flags("rst", 1'b0, 1'b0, 1'b0);

      // Idle: bytes offered without start are ignored.
      reset_n    = 1'b1;
      byte_valid = 1'b1;
      byte_in    = 8'h02;
      repeat (4) @(negedge clock);
      check("idle_ready", {31'd0, byte_ready}, 32'd0);
      check_flags("idle", 1'b0, 1'b0, 1'b0);
      byte_valid = 1'b0;
      @(negedge clock);

      // Two-word load, good checksum.
      push_wr(6'd0, 16'hA401);
      push_wr(6'd1, 16'h6000);
      do_start();
      send_byte(8'h02); send_byte(8'hA4); send_byte(8'h01);
      send_byte(8'h60); send_byte(8'h00);
      check_flags("two_pre", 1'b0, 1'b0, 1'b0);
      send_byte(8'hC5);
      check_flags("two", 1'b1, 1'b0, 1'b1);
      repeat (3) @(negedge clock);
      check_flags("two_sticky", 1'b1, 1'b0, 1'b1);
      check_drained("two");

      // Same frame, wrong checksum.
      @(negedge clock);
      push_wr(6'd0, 16'hA401);
      push_wr(6'd1, 16'h6000);
      do_start();
      check_flags("restart_clears", 1'b0, 1'b0, 1'b0);
      send_byte(8'h02); send_byte(8'hA4); send_byte(8'h01);
      send_byte(8'h60); send_byte(8'h00); send_byte(8'hC4);
      check_flags("badsum", 1'b0, 1'b1, 1'b0);
      check_drained("badsum");

      // Bad headers: zero and DEPTH+1.
      @(negedge clock);
      do_start();
      send_byte(8'h00);
      check_flags("hdr0", 1'b0, 1'b1, 1'b0);
      repeat (2) @(negedge clock);
      do_start();
      send_byte(8'h41);
      check_flags("hdr41", 1'b0, 1'b1, 1'b0);
      repeat (2) @(negedge clock);
      check_drained("hdr");

      // Full memory, valid toggled every other cycle.
      for (int k = 0; k < 64; k++) begin
         logic [7:0] kb;
         kb = 8'(k);
         push_wr(6'(k), {kb, ~kb});
      end
      do_start();
      send_byte(8'h40);
      @(negedge clock);
      for (int k = 0; k < 64; k++) begin
         logic [7:0] kb;
         kb = 8'(k);
         send_byte(kb);
         @(negedge clock);
         send_byte(~kb);
         @(negedge clock);
      end
      check_flags("full_pre", 1'b0, 1'b0, 1'b0);
      send_byte(8'h00);
      check_flags("full", 1'b1, 1'b0, 1'b1);
      check_drained("full");

      // Restart mid-frame, then a clean one-word frame.
      @(negedge clock);
      push_wr(6'd0, 16'h1234);
      push_wr(6'd0, 16'hBEEF);
      do_start();
      send_byte(8'h03); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
      do_start();
      send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF);
      send_byte(8'h51);
      check_flags("restart", 1'b1, 1'b0, 1'b1);
      repeat (3) @(negedge clock);
      check_drained("restart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
